// File: rtl/name_entry_ctrl_pkg.sv
// Shared constants and helpers for the scoreboard name-entry controller.
//   - scene encoding shared with the top-level scene FSM
//   - name/letter geometry and letter arithmetic helpers
package name_entry_ctrl_pkg;

   localparam int unsigned STATE_SIZE  = 3;
   localparam int unsigned STRING_SIZE = 15;
   localparam int unsigned CHAR_W      = 5;

   localparam logic [STATE_SIZE-1:0] SCENE_TITLE      = 3'd0;
   localparam logic [STATE_SIZE-1:0] SCENE_GAME_START = 3'd1;
   localparam logic [STATE_SIZE-1:0] SCENE_GAME       = 3'd2;
   localparam logic [STATE_SIZE-1:0] SCENE_GAME_OVER  = 3'd3;
   localparam logic [STATE_SIZE-1:0] SCENE_SCOREBOARD = 3'd4;

   localparam logic [CHAR_W-1:0] CHAR_MAX    = 5'd25;
   localparam logic [1:0]        POS_CONFIRM = 2'd3;

   function automatic logic [CHAR_W-1:0] char_inc(input logic [CHAR_W-1:0] c);
      return (c == CHAR_MAX) ? '0 : c + 1'b1;
   endfunction

   function automatic logic [CHAR_W-1:0] char_dec(input logic [CHAR_W-1:0] c);
      return (c == '0) ? CHAR_MAX : c - 1'b1;
   endfunction

   // ch0 lives in the MSBs of the name word
   function automatic logic [CHAR_W-1:0] get_char(input logic [STRING_SIZE-1:0] n,
                                                  input logic [1:0] pos);
      logic [CHAR_W-1:0] c;
      case (pos)
         2'd0:    c = n[14:10];
         2'd1:    c = n[9:5];
         default: c = n[4:0];
      endcase
      return c;
   endfunction

   function automatic logic [STRING_SIZE-1:0] set_char(input logic [STRING_SIZE-1:0] n,
                                                       input logic [1:0] pos,
                                                       input logic [CHAR_W-1:0] c);
      logic [STRING_SIZE-1:0] r;
      r = n;
      case (pos)
         2'd0:    r[14:10] = c;
         2'd1:    r[9:5]   = c;
         default: r[4:0]   = c;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/name_entry_ctrl_if.sv
// Commit bus between the name-entry controller and scoreboard storage.
//   player_name  : current 3-letter name {ch0,ch1,ch2}
//   commit_valid : name is ready to store, held until accepted
//   commit_ready : storage accepts the name while commit_valid is high
interface name_entry_ctrl_if;
   import name_entry_ctrl_pkg::*;

   logic [STRING_SIZE-1:0] player_name;
   logic                   commit_valid;
   logic                   commit_ready;

   modport master (output player_name, output commit_valid, input commit_ready);
   modport slave  (input player_name, input commit_valid, output commit_ready);
endinterface

// File: rtl/name_entry_ctrl_btn_repeat.sv
// Rising-edge detector with optional hold-to-repeat for one debounced button.
//   clk, rst   : system clock, synchronous active-high reset
//   btn_i      : debounced button level
//   rep_en_i   : auto-repeat allowed (tie low for edge-only use)
//   clr_i      : competing button held; restarts the hold count
//   step_o     : one-cycle pulse on the press edge and on every repeat step
module name_entry_ctrl_btn_repeat #(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   input  logic rep_en_i,
   input  logic clr_i,
   output logic step_o
);

   localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic             prev_q;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             edge_w, hold_w, rep_w;

   always_comb begin
      edge_w  = btn_i & ~prev_q;
      // Only a press that happened while repeat was allowed may repeat, so a
      // button already held when editing starts never auto-steps.
      hold_w  = btn_i & prev_q & armed_q & rep_en_i;
      rep_w   = hold_w & ~clr_i & (cnt_q == FIRE_AT);
      step_o  = edge_w | rep_w;
      armed_d = armed_q;
      cnt_d   = cnt_q;
      if (edge_w) begin
         armed_d = rep_en_i;
         cnt_d   = '0;
      end else if (hold_w) begin
         if (clr_i)
            cnt_d = '0;
         else if (rep_w)
            cnt_d = RELOAD;   // next step lands REPEAT_PERIOD cycles later
         else
            cnt_d = cnt_q + 1'b1;
      end else begin
         armed_d = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         prev_q  <= btn_i;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/name_entry_ctrl.sv
// Scoreboard name-entry controller: turns button presses into a 3-letter name
// and cursor position, then hands the name to storage over a valid/ready bus.
//   clk, rst       : system clock, synchronous active-high reset
//   state_i        : current scene from the top-level scene FSM
//   btn_*_i        : debounced button levels (up, down, left, right, enter)
//   input_pos_o    : cursor, 0..2 letter slot, 3 confirm box
//   editing_o      : high while the name is being edited
//   bus            : player_name / commit_valid out, commit_ready in
//
// state  | meaning
// IDLE   | not on the scoreboard scene; name keeps its last value
// EDIT   | letters and cursor follow button presses
// COMMIT | commit_valid held, buttons ignored, waiting for commit_ready
// DONE   | name stored; name and cursor frozen on display
module name_entry_ctrl
   import name_entry_ctrl_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STATE_SIZE-1:0] state_i,
   input  logic                  btn_up_i,
   input  logic                  btn_down_i,
   input  logic                  btn_left_i,
   input  logic                  btn_right_i,
   input  logic                  btn_enter_i,
   output logic [1:0]            input_pos_o,
   output logic                  editing_o,
   name_entry_ctrl_if.master     bus
);

   typedef enum logic [1:0] {IDLE, EDIT, COMMIT, DONE} fsm_e;

   fsm_e                   fsm_q;
   logic [STRING_SIZE-1:0] name_q;
   logic [1:0]             pos_q;
   logic                   valid_q;
   logic                   editing_q;

   logic up_s, down_s, left_s, right_s, enter_s;
   logic in_slot;
   logic [CHAR_W-1:0] cur_char;

   assign in_slot  = (pos_q != POS_CONFIRM);
   assign cur_char = get_char(name_q, pos_q);

   name_entry_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
      .clk(clk), .rst(rst), .btn_i(btn_up_i),
      .rep_en_i(editing_q & in_slot), .clr_i(btn_down_i), .step_o(up_s));

   name_entry_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
      .clk(clk), .rst(rst), .btn_i(btn_down_i),
      .rep_en_i(editing_q & in_slot), .clr_i(btn_up_i), .step_o(down_s));

   name_entry_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_left (
      .clk(clk), .rst(rst), .btn_i(btn_left_i),
      .rep_en_i(1'b0), .clr_i(1'b0), .step_o(left_s));

   name_entry_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_right (
      .clk(clk), .rst(rst), .btn_i(btn_right_i),
      .rep_en_i(1'b0), .clr_i(1'b0), .step_o(right_s));

   name_entry_ctrl_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_enter (
      .clk(clk), .rst(rst), .btn_i(btn_enter_i),
      .rep_en_i(1'b0), .clr_i(1'b0), .step_o(enter_s));

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= IDLE;
         name_q    <= '0;
         pos_q     <= 2'd0;
         valid_q   <= 1'b0;
         editing_q <= 1'b0;
      end else if (state_i != SCENE_SCOREBOARD) begin
         // leaving the scene aborts any pending commit without a transfer
         fsm_q     <= IDLE;
         valid_q   <= 1'b0;
         editing_q <= 1'b0;
      end else begin
         unique case (fsm_q)
            IDLE: begin
               name_q    <= '0;
               pos_q     <= 2'd0;
               fsm_q     <= EDIT;
               editing_q <= 1'b1;
            end
            EDIT: begin
               // one action per cycle: enter > up > down > left > right
               if (enter_s) begin
                  if (pos_q == POS_CONFIRM) begin
                     valid_q   <= 1'b1;
                     editing_q <= 1'b0;
                     fsm_q     <= COMMIT;
                  end else begin
                     pos_q <= pos_q + 2'd1;
                  end
               end else if (up_s && in_slot) begin
                  name_q <= set_char(name_q, pos_q, char_inc(cur_char));
               end else if (down_s && in_slot) begin
                  name_q <= set_char(name_q, pos_q, char_dec(cur_char));
               end else if (left_s) begin
                  pos_q <= pos_q - 2'd1;
               end else if (right_s) begin
                  pos_q <= pos_q + 2'd1;
               end
            end
            COMMIT: begin
               if (bus.commit_ready) begin
                  valid_q <= 1'b0;
                  fsm_q   <= DONE;
               end
            end
            DONE: begin
               fsm_q <= DONE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign bus.player_name  = name_q;
   assign bus.commit_valid = valid_q;
   assign input_pos_o      = pos_q;
   assign editing_o        = editing_q;

endmodule

// File: tb/tb_name_entry_ctrl.sv
module tb_name_entry_ctrl;
   import name_entry_ctrl_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [STATE_SIZE-1:0] state;
   logic                  btn_up, btn_down, btn_left, btn_right, btn_enter;
   logic [1:0]            input_pos;
   logic                  editing;
   int                    checks = 0;
   int                    errors = 0;

   name_entry_ctrl_if bus ();

   name_entry_ctrl #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
      .clk(clk), .rst(rst), .state_i(state),
      .btn_up_i(btn_up), .btn_down_i(btn_down), .btn_left_i(btn_left),
      .btn_right_i(btn_right), .btn_enter_i(btn_enter),
      .input_pos_o(input_pos), .editing_o(editing), .bus(bus));

   always #5 clk = ~clk;

   localparam logic [4:0] B_ENTER = 5'b10000;
   localparam logic [4:0] B_UP    = 5'b01000;
   localparam logic [4:0] B_DOWN  = 5'b00100;
   localparam logic [4:0] B_LEFT  = 5'b00010;
   localparam logic [4:0] B_RIGHT = 5'b00001;

   function automatic logic [14:0] nm(input int c0, input int c1, input int c2);
      return {5'(c0), 5'(c1), 5'(c2)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [4:0] b);
      {btn_enter, btn_up, btn_down, btn_left, btn_right} = b;
   endtask

   task automatic press(input logic [4:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         set_btns(b);
         tick();
         set_btns(5'b0);
         tick();
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [14:0] n, input logic [1:0] p,
                          input logic v, input logic e);
      chk({tag, ".name"},    32'(bus.player_name),  32'(n));
      chk({tag, ".pos"},     32'(input_pos),        32'(p));
      chk({tag, ".valid"},   32'(bus.commit_valid), 32'(v));
      chk({tag, ".editing"}, 32'(editing),          32'(e));
   endtask

   initial begin
      rst = 1'b1;
      state = SCENE_TITLE;
      set_btns(5'b0);
      bus.commit_ready = 1'b0;
      tick();
      tick();
      chk_all("reset", 15'd0, 2'd0, 1'b0, 1'b0);

      // enter the scoreboard scene
      rst = 1'b0;
      state = SCENE_SCOREBOARD;
      tick();
      chk_all("enter_edit", 15'd0, 2'd0, 1'b0, 1'b1);

      // letter stepping at pos 0
      press(B_UP, 3);
      chk("up_x3", 32'(bus.player_name), 32'(nm(3, 0, 0)));
      press(B_DOWN, 3);
      chk("down_to_0", 32'(bus.player_name), 32'(nm(0, 0, 0)));
      press(B_DOWN, 4);
      chk("down_wrap", 32'(bus.player_name), 32'(nm(22, 0, 0)));
      press(B_UP, 3);
      chk("up_to_25", 32'(bus.player_name), 32'(nm(25, 0, 0)));
      press(B_UP, 1);
      chk("up_wrap", 32'(bus.player_name), 32'(nm(0, 0, 0)));

      // cursor movement
      press(B_RIGHT, 1);  chk("right_1", 32'(input_pos), 32'd1);
      press(B_RIGHT, 1);  chk("right_2", 32'(input_pos), 32'd2);
      press(B_RIGHT, 1);  chk("right_3", 32'(input_pos), 32'd3);
      press(B_RIGHT, 1);  chk("right_wrap", 32'(input_pos), 32'd0);
      press(B_LEFT, 1);   chk("left_wrap", 32'(input_pos), 32'd3);
      press(B_UP, 1);     chk("up_at_confirm", 32'(bus.player_name), 32'(nm(0, 0, 0)));
      press(B_DOWN, 1);   chk("down_at_confirm", 32'(bus.player_name), 32'(nm(0, 0, 0)));
      press(B_RIGHT, 2);  chk("to_pos1", 32'(input_pos), 32'd1);

      // auto-repeat: press edge then 20 more held cycles; steps at hold counts 8,12,16,20
      btn_up = 1'b1;
      tick();
      chk("hold_edge", 32'(bus.player_name), 32'(nm(0, 1, 0)));
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 7) chk("hold_before_delay", 32'(bus.player_name), 32'(nm(0, 1, 0)));
         if (i == 8) chk("hold_first_repeat", 32'(bus.player_name), 32'(nm(0, 2, 0)));
      end
      chk("hold_20", 32'(bus.player_name), 32'(nm(0, 5, 0)));
      btn_up = 1'b0;
      repeat (12) tick();
      chk("hold_release", 32'(bus.player_name), 32'(nm(0, 5, 0)));

      // simultaneous up+left: only up applies
      press(B_UP | B_LEFT, 1);
      chk("prio_name", 32'(bus.player_name), 32'(nm(0, 6, 0)));
      chk("prio_pos", 32'(input_pos), 32'd1);

      // walk to confirm and commit
      press(B_LEFT, 1);   chk("back_pos0", 32'(input_pos), 32'd0);
      press(B_ENTER, 3);  chk("enter_x3", 32'(input_pos), 32'd3);
      set_btns(B_ENTER);
      tick();
      chk_all("commit", nm(0, 6, 0), 2'd3, 1'b1, 1'b0);
      set_btns(5'b0);
      tick();
      set_btns(B_UP);    tick(); chk("hold_valid_1", 32'(bus.commit_valid), 32'd1);
      set_btns(B_LEFT);  tick(); chk("hold_valid_2", 32'(bus.commit_valid), 32'd1);
      set_btns(B_ENTER); tick(); chk("hold_valid_3", 32'(bus.commit_valid), 32'd1);
      set_btns(B_DOWN);  tick(); chk("hold_valid_4", 32'(bus.commit_valid), 32'd1);
      set_btns(5'b0);    tick();
      chk_all("commit_frozen", nm(0, 6, 0), 2'd3, 1'b1, 1'b0);
      bus.commit_ready = 1'b1;
      tick();
      bus.commit_ready = 1'b0;
      chk_all("accepted", nm(0, 6, 0), 2'd3, 1'b0, 1'b0);
      press(B_UP, 1);
      press(B_RIGHT, 1);
      chk_all("done_frozen", nm(0, 6, 0), 2'd3, 1'b0, 1'b0);

      // leave and re-enter, then abort mid-commit
      state = SCENE_GAME_START;
      tick();
      state = SCENE_SCOREBOARD;
      tick();
      chk_all("reenter", 15'd0, 2'd0, 1'b0, 1'b1);
      press(B_UP, 1);
      press(B_LEFT, 1);
      press(B_ENTER, 1);
      chk("commit2_valid", 32'(bus.commit_valid), 32'd1);
      state = SCENE_GAME_START;
      tick();
      chk_all("abort", nm(1, 0, 0), 2'd3, 1'b0, 1'b0);
      repeat (3) tick();
      chk("abort_idle_valid", 32'(bus.commit_valid), 32'd0);

      // reset while editing
      state = SCENE_SCOREBOARD;
      tick();
      press(B_UP, 1);
      press(B_RIGHT, 1);
      chk("pre_rst_name", 32'(bus.player_name), 32'(nm(1, 0, 0)));
      rst = 1'b1;
      tick();
      chk_all("rst_in_edit", 15'd0, 2'd0, 1'b0, 1'b0);

      // button held across entry to EDIT never fires or repeats
      btn_up = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      repeat (14) tick();
      chk_all("held_at_entry", 15'd0, 2'd0, 1'b0, 1'b1);
      btn_up = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
